// File: rtl/ftdi_245fifo_bridge.sv
// AXI4-Stream <-> FTDI FT600/FT601 245 synchronous FIFO bridge.
// TX beats are serialized onto the chip bus; RX bus words are packed into m_axis beats.
module ftdi_245fifo_bridge #(
  parameter int FIFO_BUS_WIDTH   = 2,
  parameter int S_TDATA_WIDTH    = 4,
  parameter int M_TDATA_WIDTH    = 4,
  parameter int FIFO_DEPTH       = 2048,
  parameter int PROG_FULL_THRESH = 1024
) (
  input  logic                         usb_clk,
  input  logic                         rst_glbl,
  output logic                         usb_rstn,
  input  logic                         usb_txe_n,
  input  logic                         usb_rxf_n,
  output logic                         usb_wr_n,
  output logic                         usb_rd_n,
  output logic                         usb_oe_n,
  input  logic [FIFO_BUS_WIDTH-1:0]    usb_be_i,
  output logic [FIFO_BUS_WIDTH-1:0]    usb_be_o,
  output logic                         usb_be_t,
  input  logic [8*FIFO_BUS_WIDTH-1:0]  usb_data_i,
  output logic [8*FIFO_BUS_WIDTH-1:0]  usb_data_o,
  output logic                         usb_data_t,
  output logic [1:0]                   usb_gpio,
  output logic                         usb_siwu_n,
  output logic                         usb_wakeup_n,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [8*S_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_TDATA_WIDTH-1:0]     s_axis_tstrb,
  input  logic [S_TDATA_WIDTH-1:0]     s_axis_tkeep,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [8*M_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_TDATA_WIDTH-1:0]     m_axis_tstrb,
  output logic [M_TDATA_WIDTH-1:0]     m_axis_tkeep,
  output logic                         m_axis_tlast
);
  localparam int FB   = FIFO_BUS_WIDTH;
  localparam int BW   = 8 * FB;
  localparam int SW   = 8 * S_TDATA_WIDTH;
  localparam int MW   = 8 * M_TDATA_WIDTH;
  localparam int TWPB = S_TDATA_WIDTH / FB;
  localparam int RWPB = M_TDATA_WIDTH / FB;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TIW  = (TWPB > 1) ? $clog2(TWPB) : 1;
  localparam int RCW  = $clog2(RWPB + 1);
  localparam int TXE  = S_TDATA_WIDTH + SW;
  localparam int RXE  = 1 + FB + BW;

  typedef enum logic [2:0] {IDLE, WRITE, RD_OE, READ, TURN} state_t;
  state_t state, nxt;
  logic   from_read;

  assign usb_gpio     = 2'b00;
  assign usb_siwu_n   = 1'b1;
  assign usb_wakeup_n = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{s_axis_tstrb, s_axis_tlast};

  // ---------------- TX FIFO (one entry per s_axis beat) ----------------
  logic [TXE-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]  tx_wp, tx_rp;
  logic [AW:0]    tx_count;
  logic [TIW-1:0] widx;
  logic [TXE-1:0] tx_head;
  logic [BW-1:0]  tx_word;
  logic [FB-1:0]  tx_be;
  logic           tx_push, tx_pop, tx_take, tx_empty;

  assign s_axis_tready = !rst_glbl && (tx_count < (AW+1)'(PROG_FULL_THRESH));
  assign tx_push  = s_axis_tvalid && s_axis_tready;
  assign tx_empty = (tx_count == '0);
  assign tx_head  = tx_mem[tx_rp];
  assign tx_word  = tx_head[widx*BW +: BW];
  assign tx_be    = tx_head[SW + widx*FB +: FB];
  assign tx_take  = (state == WRITE) && !tx_empty && !usb_txe_n;
  assign tx_pop   = tx_take && (widx == TIW'(TWPB-1));

  always_ff @(posedge usb_clk)
    if (tx_push) tx_mem[tx_wp] <= {s_axis_tkeep, s_axis_tdata};

  always_ff @(posedge usb_clk or posedge rst_glbl)
    if (rst_glbl) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0; widx <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (tx_take) widx  <= tx_pop ? '0 : widx + TIW'(1);
      tx_count <= tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end

  // ---------------- RX FIFO (bus words plus burst-end markers) ----------------
  logic [RXE-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]  rx_wp, rx_rp;
  logic [AW:0]    rx_count, rx_free;
  logic [RXE-1:0] rx_din, rx_head;
  logic           rx_push_word, rx_push_mark, rx_push, rx_pop, rx_empty;

  assign rx_push_word = (state == READ) && !usb_rxf_n;
  assign rx_push_mark = (state == TURN) && from_read;
  assign rx_push      = rx_push_word || rx_push_mark;
  assign rx_din       = rx_push_mark ? {1'b1, {(FB+BW){1'b0}}} : {1'b0, usb_be_i, usb_data_i};
  assign rx_free      = (AW+1)'(FIFO_DEPTH) - rx_count;
  assign rx_empty     = (rx_count == '0);
  assign rx_head      = rx_mem[rx_rp];

  always_ff @(posedge usb_clk)
    if (rx_push) rx_mem[rx_wp] <= rx_din;

  always_ff @(posedge usb_clk or posedge rst_glbl)
    if (rst_glbl) begin
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_count <= rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end

  // ---------------- RX packer ----------------
  // A full beat is held until the next entry shows whether it ends the burst.
  logic                     h_mark, acc_full, out_free, emit;
  logic [FB-1:0]            h_be;
  logic [BW-1:0]            h_data;
  logic [MW-1:0]            acc_data;
  logic [M_TDATA_WIDTH-1:0] acc_keep;
  logic [RCW-1:0]           acc_cnt;

  assign {h_mark, h_be, h_data} = rx_head;
  assign acc_full = (acc_cnt == RCW'(RWPB));
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign rx_pop   = !rx_empty && (h_mark ? ((acc_cnt == '0) || out_free) : (!acc_full || out_free));
  assign emit     = rx_pop && (h_mark ? (acc_cnt != '0) : acc_full);
  assign m_axis_tstrb = m_axis_tkeep;

  always_ff @(posedge usb_clk or posedge rst_glbl)
    if (rst_glbl) begin
      acc_data <= '0; acc_keep <= '0; acc_cnt <= '0;
      m_axis_tvalid <= 1'b0; m_axis_tdata <= '0; m_axis_tkeep <= '0; m_axis_tlast <= 1'b0;
    end else begin
      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= acc_data;
        m_axis_tkeep  <= acc_keep;
        m_axis_tlast  <= h_mark;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (rx_pop) begin
        if (h_mark) begin
          acc_data <= '0; acc_keep <= '0; acc_cnt <= '0;
        end else if (acc_full) begin
          acc_data <= MW'(h_data);
          acc_keep <= M_TDATA_WIDTH'(h_be);
          acc_cnt  <= RCW'(1);
        end else begin
          acc_data[acc_cnt*BW +: BW] <= h_data;
          acc_keep[acc_cnt*FB +: FB] <= h_be;
          acc_cnt <= acc_cnt + RCW'(1);
        end
      end
    end

  // ---------------- bus arbiter ----------------
  always_ff @(posedge usb_clk or posedge rst_glbl)
    if (rst_glbl) begin
      state <= IDLE; from_read <= 1'b0; usb_rstn <= 1'b0;
    end else begin
      state <= nxt; from_read <= (state == READ); usb_rstn <= 1'b1;
    end

  always_comb begin
    nxt = state;
    usb_wr_n = 1'b1; usb_rd_n = 1'b1; usb_oe_n = 1'b1;
    usb_data_t = 1'b1; usb_be_t = 1'b1;
    usb_data_o = '0; usb_be_o = '0;
    case (state)
      IDLE:
        if (!usb_rxf_n && rx_free >= (AW+1)'(8)) nxt = RD_OE;
        else if (!usb_txe_n && !tx_empty)        nxt = WRITE;
      WRITE: begin
        usb_data_t = 1'b0; usb_be_t = 1'b0;
        usb_data_o = tx_word; usb_be_o = tx_be;
        usb_wr_n   = tx_empty;
        if (usb_txe_n || tx_empty) nxt = TURN;
      end
      RD_OE: begin
        usb_oe_n = 1'b0;
        nxt = READ;
      end
      READ: begin
        usb_oe_n = 1'b0; usb_rd_n = 1'b0;
        // leave room for the last capture and the burst-end marker
        if (usb_rxf_n || rx_free < (AW+1)'(4)) nxt = TURN;
      end
      TURN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ftdi_245fifo_bridge.sv
// Bench for ftdi_245fifo_bridge: chip model on the bus, scoreboards on both streams.
module tb_ftdi_245fifo_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        usb_rstn, usb_txe_n = 1'b1, rxf_n = 1'b1;
  logic        usb_wr_n, usb_rd_n, usb_oe_n, usb_be_t, usb_data_t, usb_siwu_n, usb_wakeup_n;
  logic [1:0]  usb_be_i = '0, usb_be_o, usb_gpio;
  logic [15:0] usb_data_i = '0, usb_data_o;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0, s_strb = '0;
  logic        m_valid, m_ready = 1'b0, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep, m_strb;

  ftdi_245fifo_bridge dut (
    .usb_clk(clk), .rst_glbl(rst), .usb_rstn(usb_rstn),
    .usb_txe_n(usb_txe_n), .usb_rxf_n(rxf_n),
    .usb_wr_n(usb_wr_n), .usb_rd_n(usb_rd_n), .usb_oe_n(usb_oe_n),
    .usb_be_i(usb_be_i), .usb_be_o(usb_be_o), .usb_be_t(usb_be_t),
    .usb_data_i(usb_data_i), .usb_data_o(usb_data_o), .usb_data_t(usb_data_t),
    .usb_gpio(usb_gpio), .usb_siwu_n(usb_siwu_n), .usb_wakeup_n(usb_wakeup_n),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tstrb(s_strb), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tstrb(m_strb), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, wr_cnt = 0, nbeats = 0;
  logic [17:0] txq[$], chip_q[$], burst[$];
  logic [40:0] rxq[$], obsq[$];
  logic        take = 1'b0, prev_rd_n = 1'b1, prev_oe_n = 1'b1, prev_mv = 1'b0, prev_mr = 1'b0;
  logic [37:0] prev_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chip_upd;
    rxf_n = (chip_q.size() == 0);
    if (chip_q.size() > 0) {usb_be_i, usb_data_i} = chip_q[0];
  endtask

  // reference packer: bus words of one burst -> m_axis beats, tlast on the final one
  task automatic close_burst;
    int n;
    logic [31:0] d;
    logic [3:0]  k;
    n = burst.size();
    for (int i = 0; i < n; i += 2) begin
      d = '0; k = '0;
      for (int j = 0; j < 2; j++)
        if (i + j < n) begin
          d[j*16 +: 16] = burst[i+j][15:0];
          k[j*2 +: 2]   = burst[i+j][17:16];
        end
      rxq.push_back({(i + 2 >= n), k, k, d});
    end
    burst.delete();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k);
    s_valid = 1'b1; s_data = d; s_keep = k; s_strb = k;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_ready) begin
        txq.push_back({k[1:0], d[15:0]});
        txq.push_back({k[3:2], d[31:16]});
        break;
      end
      if (t > 5000) begin chk("s_timeout", 0, 1); break; end
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_txq(input int lim);
    for (int t = 0; t < lim && txq.size() != 0; t++) tick();
    chk("tx_drain", txq.size(), 0);
  endtask

  task automatic wait_rx_done(input int lim);
    for (int t = 0; t < lim; t++) begin
      if (chip_q.size() == 0 && burst.size() == 0 && rxq.size() == 0 && obsq.size() == 0 && usb_rd_n) break;
      tick();
    end
    chk("rx_drain", {chip_q.size() == 0, rxq.size() == 0, obsq.size() == 0}, 3'b111);
  endtask

  // chip side of the read handshake: a word leaves the chip on an edge with rd_n=0, rxf_n=0
  always @(posedge clk)
    if (take) begin
      #1;
      burst.push_back(chip_q.pop_front());
      chip_upd();
    end

  always @(negedge clk) begin
    if (!rst) begin
      if (!usb_wr_n) begin
        chk("wr_oe_excl", usb_oe_n, 1);
        chk("wr_drive", usb_data_t, 0);
      end
      if (!usb_oe_n) chk("rd_hiz", usb_data_t, 1);
      if (!usb_wr_n && !usb_txe_n) begin
        wr_cnt++;
        if (txq.size() == 0) chk("tx_extra", {usb_be_o, usb_data_o}, 18'h3ffff);
        else chk("tx_word", {usb_be_o, usb_data_o}, txq.pop_front());
      end
      take = !usb_rd_n && !rxf_n;
      if (prev_rd_n && !usb_rd_n) chk("oe_lead", prev_oe_n, 0);
      if (!prev_rd_n && usb_rd_n) close_burst();
      if (prev_mv && !prev_mr) chk("m_hold", {m_valid, m_last, m_keep, m_data}, prev_m);
      if (m_valid && m_ready) begin
        obsq.push_back({m_last, m_strb, m_keep, m_data});
        nbeats++;
      end
      while (obsq.size() > 0 && rxq.size() > 0) chk("rx_beat", obsq.pop_front(), rxq.pop_front());
    end else take = 1'b0;
    prev_rd_n = usb_rd_n; prev_oe_n = usb_oe_n;
    prev_mv = m_valid; prev_mr = m_ready;
    prev_m = {m_valid, m_last, m_keep, m_data};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    chip_upd();
    // reset
    repeat (10) @(posedge clk);
    #1;
    chk("rst_strobes", {usb_wr_n, usb_rd_n, usb_oe_n}, 3'b111);
    chk("rst_tris", {usb_data_t, usb_be_t}, 2'b11);
    chk("rst_drive", {usb_be_o, usb_data_o}, 0);
    chk("rst_rstn", usb_rstn, 0);
    chk("rst_axis", {s_ready, m_valid}, 2'b00);
    chk("rst_misc", {usb_gpio, usb_siwu_n, usb_wakeup_n}, 4'b0011);
    rst = 1'b0;
    @(negedge clk); chk("rstn_hold", usb_rstn, 0);
    @(negedge clk); chk("rstn_rise", usb_rstn, 1);
    tick();

    // TX single beat
    usb_txe_n = 1'b0; wr_cnt = 0;
    send_beat(32'h44332211, 4'hF);
    wait_txq(100);
    chk("tx_wr_edges", wr_cnt, 2);
    repeat (4) tick();

    // TX stall mid-beat, then a beat with an all-zero-keep word
    usb_txe_n = 1'b1; wr_cnt = 0;
    send_beat(32'h88776655, 4'hF);
    send_beat(32'hDDCCBBAA, 4'b0100);
    usb_txe_n = 1'b0;
    tick(); tick();
    usb_txe_n = 1'b1;
    repeat (5) tick();
    chk("stall_cnt", wr_cnt, 1);
    usb_txe_n = 1'b0;
    wait_txq(100);
    chk("stall_total", wr_cnt, 4);
    repeat (4) tick();

    // RX 4 words
    m_ready = 1'b1; nb = nbeats;
    chip_q.push_back({2'b11, 16'hA1A0}); chip_q.push_back({2'b11, 16'hA3A2});
    chip_q.push_back({2'b11, 16'hA5A4}); chip_q.push_back({2'b11, 16'hA7A6});
    chip_upd();
    wait_rx_done(200);
    chk("rx4_beats", nbeats - nb, 2);

    // RX odd word count
    nb = nbeats;
    chip_q.push_back({2'b11, 16'hB1B0}); chip_q.push_back({2'b11, 16'hB3B2});
    chip_q.push_back({2'b11, 16'hB5B4});
    chip_upd();
    wait_rx_done(200);
    chk("rx3_beats", nbeats - nb, 2);

    // RX backpressure until the FIFO nearly fills
    m_ready = 1'b0;
    for (int i = 0; i < 2100; i++) chip_q.push_back({2'b11, 16'(i)});
    chip_upd();
    repeat (2300) tick();
    chk("bp_rd_n", usb_rd_n, 1);
    chk("bp_taken", 2100 - chip_q.size(), 2050);
    for (int t = 0; t < 20000; t++) begin
      if (chip_q.size() == 0 && burst.size() == 0 && rxq.size() == 0 && obsq.size() == 0 && usb_rd_n) break;
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    wait_rx_done(200);

    // programmable-full threshold
    usb_txe_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 1024; i++) send_beat($urandom, 4'hF);
    @(negedge clk); chk("pf_tready", s_ready, 0);
    tick();
    usb_txe_n = 1'b0;
    for (int t = 0; t < 100 && !s_ready; t++) tick();
    chk("pf_resume", s_ready, 1);
    wait_txq(5000);
    repeat (4) tick();

    // reset mid-transfer discards FIFO contents
    usb_txe_n = 1'b1;
    for (int i = 0; i < 4; i++) send_beat($urandom, 4'hF);
    usb_txe_n = 1'b0;
    for (int t = 0; t < 50 && usb_wr_n; t++) tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {usb_wr_n, usb_rd_n, usb_oe_n, usb_data_t, usb_be_t}, 5'h1f);
    chk("mid_rst_out", {usb_rstn, s_ready, m_valid, usb_be_o, usb_data_o}, 0);
    txq.delete();
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_flush", usb_wr_n, 1);

    chk("end_queues", {txq.size() == 0, rxq.size() == 0, obsq.size() == 0}, 3'b111);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
